// File: rtl/ram_dp_param_pkg.sv
// ram_dp_param_pkg
// Shared definitions for the parametrised data/instruction RAM family.
// Holds the clear-sequencer state encoding and the default geometry that
// future caches and ROMs reuse.
package ram_dp_param_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq
// Walks a pointer over every implemented word after reset or a clear
// request, and tells the RAM top level which word to zero each cycle.
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (restarts the clear at 0)
//   clr_i       clear request, honoured only while READY
//   busy_o      clear in progress
//   clr_we_o    zeroing write enable for the array
//   clr_addr_o  word being zeroed this cycle
module ram_clear_seq
  import ram_dp_param_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << DEF_ADDR_W,
  parameter int IDX_W  = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [IDX_W-1:0] clr_addr_o
);

  // One extra bit so the pointer cannot wrap when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  ram_state_e      state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    clr_we_o   = (state_q == ST_CLEAR);
    clr_addr_o = ptr_q[IDX_W-1:0];
  end

endmodule

// File: rtl/ram_dp_param.sv
// ram_dp_param
// Parametrised simple dual-port RAM (one write port, one read port) with a
// registered, write-first read and a hardware clear sequencer that zeroes
// the whole array after reset or on request. The core stalls while busy.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   waddr   write address          wdata  write data
//   str     write strobe
//   raddr   read address           ld     read request
//   clr     single-cycle pulse: re-zero the array
//   rdata   registered read data
//   rvalid  rdata refreshed by an accepted ld this cycle
//   rerr    accepted ld addressed a word >= DEPTH
//   busy    clear in progress, port requests ignored
module ram_dp_param
  import ram_dp_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              str,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ld,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rerr,
  output logic              busy
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             seq_busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_addr;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              waddr_ok, raddr_ok, rd_acc;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rerr_q, rerr_d;

  ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .busy_o     (seq_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Zero-extended compares keep DEPTH == 2**ADDR_W representable.
  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);

  // A read in the same cycle as a clear request is dropped.
  assign rd_acc = ld && !seq_busy && !clr;

  // The clear sequencer owns the write port while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr[IDX_W-1:0];
    mem_wdata = wdata;
    if (seq_busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (str && waddr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Write-first: a same-cycle write to the read address forwards wdata.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    if (rd_acc) begin
      rvalid_d = 1'b1;
      if (!raddr_ok) begin
        rdata_d = '0;
        rerr_d  = 1'b1;
      end else if (str && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[raddr[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rerr   = rerr_q;
  assign busy   = seq_busy;

endmodule

// File: tb/tb_ram_dp_param.sv
module tb_ram_dp_param;

  logic        clk;
  logic        rst_n, str, ld, clr;
  logic [9:0]  waddr, raddr;
  logic [19:0] wdata;

  logic [19:0] rdata  [3];
  logic        rvalid [3];
  logic        rerr   [3];
  logic        busy   [3];

  int checks = 0;
  int errors = 0;

  // Reference model: one array per instance, clear countdown per instance.
  int          dep [3] = '{1024, 1000, 16};
  logic [19:0] mdl [3][1024];
  int          bcnt [3];
  logic [19:0] e_rdata  [3];
  logic        e_rvalid [3];
  logic        e_rerr   [3];

  ram_dp_param dut_a (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .str(str),
    .raddr(raddr), .ld(ld), .clr(clr), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .rerr(rerr[0]), .busy(busy[0])
  );

  ram_dp_param #(.DATA_W(20), .ADDR_W(10), .DEPTH(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .str(str),
    .raddr(raddr), .ld(ld), .clr(clr), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .rerr(rerr[1]), .busy(busy[1])
  );

  ram_dp_param #(.DATA_W(20), .ADDR_W(10), .DEPTH(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .str(str),
    .raddr(raddr), .ld(ld), .clr(clr), .rdata(rdata[2]), .rvalid(rvalid[2]),
    .rerr(rerr[2]), .busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply the current inputs at the next edge, advance the model, and
  // return 1 time unit after the edge.
  task automatic cycle();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        bcnt[k] = dep[k];
        e_rdata[k] = '0; e_rvalid[k] = 1'b0; e_rerr[k] = 1'b0;
      end else if (bcnt[k] > 0) begin
        mdl[k][dep[k] - bcnt[k]] = '0;
        bcnt[k]--;
        e_rvalid[k] = 1'b0; e_rerr[k] = 1'b0;
      end else begin
        e_rvalid[k] = 1'b0; e_rerr[k] = 1'b0;
        if (ld && !clr) begin
          e_rvalid[k] = 1'b1;
          if (int'(raddr) >= dep[k]) begin
            e_rdata[k] = '0; e_rerr[k] = 1'b1;
          end else if (str && waddr == raddr) begin
            e_rdata[k] = wdata;
          end else begin
            e_rdata[k] = mdl[k][raddr];
          end
        end
        if (str && int'(waddr) < dep[k]) mdl[k][waddr] = wdata;
        if (clr) bcnt[k] = dep[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    str = 1'b0; ld = 1'b0; clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] !== 1'b0 || busy[1] !== 1'b0 || busy[2] !== 1'b0) && n < 1200) begin
      n++;
      cycle();
    end
    if (n >= 1200) begin
      checks++; errors++;
      $display("FAIL wait_idle busy=%b%b%b after %0d cycles, want 000", busy[0], busy[1], busy[2], n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; idle_inputs();
    waddr = '0; raddr = '0; wdata = '0;
    cycle(); cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b1 || rvalid[k] !== 1'b0 || rerr[k] !== 1'b0 || rdata[k] !== 20'd0) begin
        errors++;
        $display("FAIL reset_state[%0d] busy=%b rvalid=%b rerr=%b rdata=%0d, want 1 0 0 0",
                 k, busy[k], rvalid[k], rerr[k], rdata[k]);
      end
    end
    rst_n = 1'b1;
    ld = 1'b1; str = 1'b1; waddr = 10'd2; wdata = 20'd9; raddr = 10'd2;
    n = 0;
    while (busy[2] === 1'b1 && n < 100) begin
      checks++;
      if (rvalid[2] !== 1'b0 || rerr[2] !== 1'b0) begin
        errors++;
        $display("FAIL clear_quiet rvalid=%b rerr=%b, want 0 0", rvalid[2], rerr[2]);
      end
      n++;
      cycle();
    end
    idle_inputs();
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reset_busy_len got %0d cycles, want 16", n);
    end
    wait_idle();
    for (int a = 0; a < 16; a++) begin
      ld = 1'b1; raddr = 10'(a);
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rdata[k] !== 20'd0 || rvalid[k] !== 1'b1 || rerr[k] !== 1'b0) begin
          errors++;
          $display("FAIL idle_read[%0d] addr=%0d rdata=%0d rvalid=%b rerr=%b, want 0 1 0",
                   k, a, rdata[k], rvalid[k], rerr[k]);
        end
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_write_read();
    str = 1'b1; waddr = 10'd1; wdata = 20'd202; cycle();
    str = 1'b0; ld = 1'b1; raddr = 10'd1; cycle();
    ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdata[k] !== 20'd202 || rvalid[k] !== 1'b1) begin
        errors++;
        $display("FAIL wr_rd_1[%0d] rdata=%0d rvalid=%b, want 202 1", k, rdata[k], rvalid[k]);
      end
    end
    str = 1'b1; waddr = 10'd1023; wdata = 20'hFFFFF; cycle();
    str = 1'b0; ld = 1'b1; raddr = 10'd1023; cycle();
    ld = 1'b0;
    checks++;
    if (rdata[0] !== 20'hFFFFF || rerr[0] !== 1'b0 || rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_top rdata=%h rerr=%b rvalid=%b, want fffff 0 1", rdata[0], rerr[0], rvalid[0]);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (rdata[k] !== 20'd0 || rerr[k] !== 1'b1) begin
        errors++;
        $display("FAIL wr_rd_top_oor[%0d] rdata=%h rerr=%b, want 0 1", k, rdata[k], rerr[k]);
      end
    end
    cycle();
  endtask

  task automatic test_same_addr();
    str = 1'b1; waddr = 10'd3; wdata = 20'd404; cycle();
    wdata = 20'd505; ld = 1'b1; raddr = 10'd3; cycle();
    str = 1'b0;
    checks++;
    if (rdata[0] !== 20'd505 || rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL same_addr_bypass rdata=%0d rvalid=%b, want 505 1", rdata[0], rvalid[0]);
    end
    cycle();
    ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdata[k] !== 20'd505) begin
        errors++;
        $display("FAIL same_addr_next[%0d] rdata=%0d, want 505", k, rdata[k]);
      end
    end
    cycle();
  endtask

  task automatic test_out_of_range();
    str = 1'b1; waddr = 10'd999; wdata = 20'd31; cycle();
    waddr = 10'd1000; wdata = 20'd77; cycle();
    str = 1'b0; ld = 1'b1; raddr = 10'd1000; cycle();
    checks++;
    if (rdata[1] !== 20'd0 || rerr[1] !== 1'b1 || rvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_read rdata=%0d rerr=%b rvalid=%b, want 0 1 1", rdata[1], rerr[1], rvalid[1]);
    end
    checks++;
    if (rdata[0] !== 20'd77 || rerr[0] !== 1'b0) begin
      errors++;
      $display("FAIL inrange_1000 rdata=%0d rerr=%b, want 77 0", rdata[0], rerr[0]);
    end
    raddr = 10'd999; cycle();
    ld = 1'b0;
    checks++;
    if (rdata[1] !== 20'd31 || rerr[1] !== 1'b0 || rvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL read_999 rdata=%0d rerr=%b rvalid=%b, want 31 0 1", rdata[1], rerr[1], rvalid[1]);
    end
    cycle();
    checks++;
    if (rvalid[1] !== 1'b0 || rerr[1] !== 1'b0 || rdata[1] !== 20'd31) begin
      errors++;
      $display("FAIL oor_idle rvalid=%b rerr=%b rdata=%0d, want 0 0 31", rvalid[1], rerr[1], rdata[1]);
    end
  endtask

  task automatic test_stream();
    logic [19:0] vals [4] = '{20'd202, 20'd303, 20'd404, 20'd505};
    for (int i = 0; i < 4; i++) begin
      str = 1'b1; waddr = 10'(i + 1); wdata = vals[i]; cycle();
    end
    str = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld = 1'b1; raddr = 10'(i + 1); cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rdata[k] !== vals[i] || rvalid[k] !== 1'b1) begin
          errors++;
          $display("FAIL stream[%0d] beat %0d rdata=%0d rvalid=%b, want %0d 1", k, i, rdata[k], rvalid[k], vals[i]);
        end
      end
    end
    ld = 1'b0; cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rvalid[k] !== 1'b0 || rdata[k] !== 20'd505) begin
        errors++;
        $display("FAIL stream_hold[%0d] rvalid=%b rdata=%0d, want 0 505", k, rvalid[k], rdata[k]);
      end
    end
  endtask

  task automatic test_clr_reset();
    int n, na, nb, nc;
    str = 1'b1; waddr = 10'd0; wdata = 20'd101; cycle();
    // clear request with a concurrent write and read
    clr = 1'b1; ld = 1'b1; raddr = 10'd0; waddr = 10'd5; wdata = 20'd55; cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rvalid[k] !== 1'b0 || busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL clr_entry[%0d] rvalid=%b busy=%b, want 0 1", k, rvalid[k], busy[k]);
      end
    end
    n = 0;
    while (busy[2] === 1'b1 && n < 2000) begin n++; cycle(); end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clr_busy_len got %0d cycles, want 16", n);
    end
    wait_idle();
    ld = 1'b1; raddr = 10'd0; cycle();
    checks++;
    if (rdata[0] !== 20'd0 || rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_read0 rdata=%0d rvalid=%b, want 0 1", rdata[0], rvalid[0]);
    end
    raddr = 10'd5; cycle();
    ld = 1'b0;
    checks++;
    if (rdata[0] !== 20'd0) begin
      errors++;
      $display("FAIL clr_read5 rdata=%0d, want 0", rdata[0]);
    end
    // reset asserted part-way into a clear restarts it
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    na = 0; nb = 0; nc = 0; n = 0;
    while ((busy[0] === 1'b1 || busy[1] === 1'b1 || busy[2] === 1'b1) && n < 3000) begin
      if (busy[0] === 1'b1) na++;
      if (busy[1] === 1'b1) nb++;
      if (busy[2] === 1'b1) nc++;
      n++;
      cycle();
    end
    checks++;
    if (na !== 1024 || nb !== 1000 || nc !== 16) begin
      errors++;
      $display("FAIL midclear_reset busy lens %0d/%0d/%0d, want 1024/1000/16", na, nb, nc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      str   = ($urandom_range(0, 1) == 1);
      ld    = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 199) == 0);
      waddr = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 20));
      raddr = ($urandom_range(0, 2) == 0) ? waddr
            : (($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 20)));
      wdata = 20'($urandom);
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rvalid[k] !== e_rvalid[k] || rerr[k] !== e_rerr[k] || rdata[k] !== e_rdata[k]
            || busy[k] !== (bcnt[k] > 0)) begin
          errors++;
          $display("FAIL rnd[%0d] i=%0d rdata=%h rvalid=%b rerr=%b busy=%b, want %h %b %b %b",
                   k, i, rdata[k], rvalid[k], rerr[k], busy[k], e_rdata[k], e_rvalid[k], e_rerr[k], bcnt[k] > 0);
        end
      end
    end
    idle_inputs();
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_addr();
    test_out_of_range();
    test_stream();
    test_clr_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
- Parametrised successor to the single-port 20-bit/1024-word data RAM.
- Separate write and read ports, both usable in the same cycle.
- Registered read with a valid flag; a hardware clear sequencer zeroes the whole array after reset or on request.
- Instantiated as CPU data/instruction memory; the core stalls while busy=1.

Parameters:
- DATA_W, 20, word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDR_W and ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- str  in  1  write strobe; stores on the rising edge.
- raddr  in  ADDR_W  read address.
- ld  in  1  read request.
- clr  in  1  single-cycle pulse: re-zero the array.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata updated this cycle by an accepted ld.
- rerr  out  1  accepted ld had raddr ≥ DEPTH.
- busy  out  1  clear in progress; port requests are ignored.

Behaviour:
- Reset (rst_n=0 at posedge):
  - rdata=0, rvalid=0, rerr=0, busy=1.
  - Clear pointer=0; state=CLEAR.
  - Array contents are not reset directly.
  - Reset asserted mid-clear restarts the clear from address 0.
- States: CLEAR, READY.
- CLEAR:
  - Each cycle: mem[ptr]<=0, ptr<=ptr+1.
  - On the edge that writes DEPTH-1: state<=READY, busy<=0.
  - Duration is exactly DEPTH cycles after rst_n releases; busy reads 0 in the cycle after the last write.
  - str, ld and clr are ignored; rvalid=0 and rerr=0 throughout.
- READY, write:
  - str=1 and waddr<DEPTH: mem[waddr]<=wdata on the same edge.
  - waddr≥DEPTH: write dropped, no side effects.
- READY, read (latency 1):
  - ld=1 at edge N → rdata/rvalid/rerr valid after edge N, for one cycle.
  - raddr<DEPTH: rdata<=mem[raddr], rerr<=0.
  - raddr≥DEPTH: rdata<=0, rerr<=1.
  - ld=0: rvalid<=0, rerr<=0, rdata holds its previous value.
- Same-cycle str and ld with waddr==raddr<DEPTH: write-first; rdata<=wdata and the memory is also written.
- clr=1 in READY:
  - Enter CLEAR with ptr=0, busy=1 from the next cycle.
  - Any str in that same cycle is still performed, but is overwritten by the clear.
  - Any ld in that same cycle is dropped (rvalid=0).
- Counter and width rules:
  - ptr is ADDR_W+1 bits wide to avoid wrap at DEPTH=2^ADDR_W.
  - Comparisons are unsigned.
  - Back-to-back reads at the same or different addresses give one rvalid per cycle; no bubbles.

Decomposition:
- Shared include Memory/mem_defs.vh holds:
  - state encodings ST_CLEAR=1'b0, ST_READY=1'b1;
  - default DATA_W/ADDR_W constants, reused by future caches/ROMs.
- One natural sub-module, ram_clear_seq:
  - contents: the pointer counter plus CLEAR/READY state;
  - outputs: busy, clear write-enable, clear address;
  - the top level muxes the clear write over the user write port.

Test Plan:
- Reset then idle (DEPTH=16): rst_n low 2 cycles, then high → busy=1 for exactly 16 cycles, then 0; ld at addr 0..15 returns 0 with rvalid=1 and rerr=0.
- Write/read (defaults): str waddr=1 wdata=202, then ld raddr=1 → rvalid=1 one cycle later with rdata=202. Then waddr=1023 wdata=20'hFFFFF followed by a read → rdata=20'hFFFFF.
- Simultaneous same address: mem[3]=404; same cycle str waddr=3 wdata=505 and ld raddr=3 → rdata=505. Next-cycle read of address 3 → 505.
- Out of range (DEPTH=1000): str waddr=1000 wdata=77, then ld raddr=1000 → rdata=0, rerr=1, rvalid=1. A read of address 999 is unaffected.
- Mid-operation reset and clr: write 101 to addr 0, pulse clr → busy=1 for DEPTH cycles, and a following read of addr 0 returns 0. Assert rst_n=0 at clear cycle 5 → the clear restarts and busy lasts a full DEPTH cycles after release.
- Hold and stream: ld=1 for 4 consecutive cycles over addr 1..4 holding 202/303/404/505 → rvalid=1 for 4 cycles with data in order. Then ld=0 → rvalid=0 and rdata holds 505.
